// File: rtl/peak_detect_frame_pkg.sv
// Shared constants for the peak detector slice: sample/index widths and the
// default frame geometry used by peak_detect_frame and its result register.
package peak_detect_frame_pkg;

  localparam int VALUE_WIDTH   = 24;    // significant LSBs of the power sample
  localparam int INDEX_WIDTH   = 10;    // bin index width
  localparam int DEF_FRAME_LEN = 1024;  // expected beats per frame
  localparam int DEF_MIN_IDX   = 2;     // DC guard: lower bins never peak

endpackage

// File: rtl/peak_detect_frame_result_reg.sv
// peak_result_reg: single-entry AXIS holding register. A load while the
// previous result is still pending (and not being accepted this cycle)
// overwrites it and raises the sticky overrun flag. Also used by the
// peak-report logic.
module peak_result_reg
  import peak_detect_frame_pkg::*;
#(
  parameter int DATA_W = VALUE_WIDTH + INDEX_WIDTH + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              clear_err,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_data,
  output logic              overrun
);

  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;
  logic              overrun_reg;
  logic              overwrite;

  // Losing a result: something pending, not accepted now, and a new load.
  assign overwrite = load && valid_reg && !m_axis_tready;

  // Entry holds its fields until accepted; a load always takes priority.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
    end else if (valid_reg && m_axis_tready) begin
      valid_reg <= 1'b0;
    end
  end

  // Sticky overrun; a coincident clear loses against a new overwrite.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overrun_reg <= 1'b0;
    end else if (overwrite) begin
      overrun_reg <= 1'b1;
    end else if (clear_err) begin
      overrun_reg <= 1'b0;
    end
  end

  assign m_axis_tvalid = valid_reg;
  assign m_data        = data_reg;
  assign overrun       = overrun_reg;

endmodule

// File: rtl/peak_detect_frame.sv
// peak_detect_frame: per-channel, per-frame peak finder on a 32-bit AXIS
// power stream with aligned bin index. One result beat per tlast-delimited
// frame, one cycle after the tlast beat.
// Optional feature macro: PEAK_ABOVE_COUNT_EN adds m_peak_count, the
// saturating number of qualifying beats in the frame.
module peak_detect_frame
  import peak_detect_frame_pkg::*;
#(
  parameter int VALUE_W   = VALUE_WIDTH,
  parameter int IDX_W     = INDEX_WIDTH,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int MIN_IDX   = DEF_MIN_IDX
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [31:0]        s_axis_tdata,
  input  logic               s_axis_tvalid,
  input  logic               s_axis_tlast,
  output logic               s_axis_tready,
  input  logic [IDX_W-1:0]   xk_in,
  input  logic [VALUE_W-1:0] threshold,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [VALUE_W-1:0] m_peak_value,
  output logic [IDX_W-1:0]   m_peak_index,
  output logic               m_peak_found,
  output logic               overrun,
  output logic               len_err,
  input  logic               clear_err
`ifdef PEAK_ABOVE_COUNT_EN
  ,
  output logic [IDX_W:0]     m_peak_count
`endif
);

  localparam int CNT_W = IDX_W + 1;
`ifdef PEAK_ABOVE_COUNT_EN
  localparam int RES_W = CNT_W + 1 + IDX_W + VALUE_W;
`else
  localparam int RES_W = 1 + IDX_W + VALUE_W;
`endif

  logic [VALUE_W-1:0] sample_value;
  logic               first_beat;
  logic [VALUE_W-1:0] thr_eff;
  logic               qualify;
  logic               take;
  logic               frame_len_bad;
  logic               frame_end;

  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [VALUE_W-1:0] thr_reg;
  logic               found_reg, found_next;
  logic [VALUE_W-1:0] best_val_reg, best_val_next;
  logic [IDX_W-1:0]   best_idx_reg, best_idx_next;
  logic               len_err_reg;
  logic [RES_W-1:0]   res_in, res_out;

  // Upper sample bits carry no information for this channel.
  generate
    if (VALUE_W < 32) begin : g_unused_hi
      logic unused_tdata_hi;
      assign unused_tdata_hi = ^s_axis_tdata[31:VALUE_W];
    end
  endgenerate

  assign s_axis_tready = 1'b1;
  assign sample_value  = s_axis_tdata[VALUE_W-1:0];
  assign frame_end     = s_axis_tvalid && s_axis_tlast;

  // The counter saturates and never returns to zero inside a frame, so zero
  // marks the first beat; that beat uses the live threshold directly.
  assign first_beat = (cnt_reg == '0);
  assign thr_eff    = first_beat ? threshold : thr_reg;
  assign qualify    = (xk_in >= IDX_W'(MIN_IDX)) && (sample_value >= thr_eff);
  // Strict > keeps the earliest bin on ties.
  assign take       = qualify && (!found_reg || (sample_value > best_val_reg));

  assign found_next    = found_reg | qualify;
  assign best_val_next = take ? sample_value : best_val_reg;
  assign best_idx_next = take ? xk_in : best_idx_reg;
  assign cnt_next      = (cnt_reg == '1) ? cnt_reg : cnt_reg + CNT_W'(1);
  assign frame_len_bad = (({1'b0, cnt_reg} + (CNT_W + 1)'(1)) != (CNT_W + 1)'(FRAME_LEN));

  // Accumulate across the frame; tlast hands off to the result register and
  // leaves everything clear for the next frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_reg      <= '0;
      thr_reg      <= '0;
      found_reg    <= 1'b0;
      best_val_reg <= '0;
      best_idx_reg <= '0;
    end else if (s_axis_tvalid) begin
      if (s_axis_tlast) begin
        cnt_reg      <= '0;
        found_reg    <= 1'b0;
        best_val_reg <= '0;
        best_idx_reg <= '0;
      end else begin
        cnt_reg      <= cnt_next;
        found_reg    <= found_next;
        best_val_reg <= best_val_next;
        best_idx_reg <= best_idx_next;
        if (first_beat) thr_reg <= threshold;
      end
    end
  end

  // Sticky length error; a new error outranks a coincident clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_err_reg <= 1'b0;
    end else if (frame_end && frame_len_bad) begin
      len_err_reg <= 1'b1;
    end else if (clear_err) begin
      len_err_reg <= 1'b0;
    end
  end

  assign len_err = len_err_reg;

`ifdef PEAK_ABOVE_COUNT_EN
  logic [CNT_W-1:0] qcnt_reg, qcnt_next;

  assign qcnt_next = (qualify && (qcnt_reg != '1)) ? qcnt_reg + CNT_W'(1) : qcnt_reg;

  // Count of qualifying beats, cleared with the rest of the accumulator.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      qcnt_reg <= '0;
    end else if (s_axis_tvalid) begin
      qcnt_reg <= s_axis_tlast ? '0 : qcnt_next;
    end
  end

  assign res_in = {qcnt_next, found_next, best_idx_next, best_val_next};
  assign {m_peak_count, m_peak_found, m_peak_index, m_peak_value} = res_out;
`else
  assign res_in = {found_next, best_idx_next, best_val_next};
  assign {m_peak_found, m_peak_index, m_peak_value} = res_out;
`endif

  // With no qualifying bin the accumulator never moved, so value/index are 0.
  peak_result_reg #(
    .DATA_W(RES_W)
  ) u_result (
    .clk          (clk),
    .rstn         (rstn),
    .load         (frame_end),
    .load_data    (res_in),
    .clear_err    (clear_err),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_data       (res_out),
    .overrun      (overrun)
  );

endmodule

// File: tb/tb_peak_detect_frame.sv
// Directed bench for peak_detect_frame with FRAME_LEN=8, MIN_IDX=2.
// Build with PEAK_ABOVE_COUNT_EN defined to also check m_peak_count.
module tb_peak_detect_frame;

  localparam int VW = 24;
  localparam int IW = 10;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [31:0]   s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [IW-1:0] xk_in = '0;
  logic [VW-1:0] threshold = '0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic [VW-1:0] m_peak_value;
  logic [IW-1:0] m_peak_index;
  logic          m_peak_found;
  logic          overrun;
  logic          len_err;
  logic          clear_err = 1'b0;
`ifdef PEAK_ABOVE_COUNT_EN
  logic [IW:0]   m_peak_count;
`endif

  int checks = 0;
  int failures = 0;

  logic [VW-1:0] vals [8] = '{24'd50, 24'd3, 24'd7, 24'd40, 24'd90, 24'd12, 24'd90, 24'd5};

  always #5 clk = ~clk;

  peak_detect_frame #(
    .VALUE_W  (VW),
    .IDX_W    (IW),
    .FRAME_LEN(8),
    .MIN_IDX  (2)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .xk_in        (xk_in),
    .threshold    (threshold),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_peak_value (m_peak_value),
    .m_peak_index (m_peak_index),
    .m_peak_found (m_peak_found),
    .overrun      (overrun),
    .len_err      (len_err),
    .clear_err    (clear_err)
`ifdef PEAK_ABOVE_COUNT_EN
    ,
    .m_peak_count (m_peak_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One beat: driven on the falling edge, sampled on the next rising edge,
  // returns 1 time unit after that edge with tvalid dropped.
  task automatic beat(input logic [VW-1:0] v, input logic [IW-1:0] i, input logic last);
    @(negedge clk);
    s_axis_tdata  = {8'hA5, v};
    xk_in         = i;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // First n entries of vals at index 0..n-1, with gap idle cycles between beats.
  task automatic send_frame(input int n, input logic [VW-1:0] thr, input int gap);
    threshold = thr;
    for (int i = 0; i < n; i++) begin
      beat(vals[i], IW'(i), (i == n - 1));
      if (i != n - 1) repeat (gap) @(posedge clk);
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_err = 1'b1;
    @(posedge clk);
    #1;
    clear_err = 1'b0;
  endtask

  task automatic show(input string name);
    $display("%s: tvalid=%0d value=%0d index=%0d found=%0d overrun=%0d len_err=%0d",
             name, m_axis_tvalid, m_peak_value, m_peak_index, m_peak_found, overrun, len_err);
  endtask

  initial begin
    // Reset state
    #22;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tready", s_axis_tready, 1);
    check("rst_value", m_peak_value, 0);
    check("rst_overrun", overrun, 0);
    check("rst_len_err", len_err, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Basic frame, threshold 10: peak 90 at idx 4 (tie at idx 6 loses)
    send_frame(8, 24'd10, 0);
    show("frame_basic");
    check("basic_tvalid", m_axis_tvalid, 1);
    check("basic_value", m_peak_value, 90);
    check("basic_index", m_peak_index, 4);
    check("basic_found", m_peak_found, 1);
    check("basic_len_err", len_err, 0);
`ifdef PEAK_ABOVE_COUNT_EN
    check("basic_count", m_peak_count, 4);
`endif
    @(posedge clk); #1;
    check("basic_tvalid_drop", m_axis_tvalid, 0);

    // Same frame, threshold 100: nothing qualifies
    send_frame(8, 24'd100, 0);
    show("frame_none");
    check("none_tvalid", m_axis_tvalid, 1);
    check("none_found", m_peak_found, 0);
    check("none_value", m_peak_value, 0);
    check("none_index", m_peak_index, 0);
`ifdef PEAK_ABOVE_COUNT_EN
    check("none_count", m_peak_count, 0);
`endif
    @(posedge clk); #1;

    // Overrun: tready low across two frames
    m_axis_tready = 1'b0;
    send_frame(8, 24'd10, 0);
    show("frame_hold1");
    check("ovr_first_overrun", overrun, 0);
    check("ovr_first_value", m_peak_value, 90);
    repeat (3) @(posedge clk);
    #1;
    check("ovr_hold_value", m_peak_value, 90);
    check("ovr_hold_tvalid", m_axis_tvalid, 1);
    send_frame(8, 24'd100, 0);
    show("frame_hold2");
    check("ovr_second_tvalid", m_axis_tvalid, 1);
    check("ovr_second_found", m_peak_found, 0);
    check("ovr_second_overrun", overrun, 1);
    pulse_clear();
    check("ovr_cleared", overrun, 0);
    m_axis_tready = 1'b1;
    @(posedge clk); #1;
    check("ovr_drained", m_axis_tvalid, 0);

    // Short frame sets len_err; correct frame leaves it set until cleared
    send_frame(6, 24'd10, 0);
    show("frame_short");
    check("short_len_err", len_err, 1);
    check("short_tvalid", m_axis_tvalid, 1);
    check("short_value", m_peak_value, 90);
    send_frame(8, 24'd10, 0);
    show("frame_after_short");
    check("sticky_len_err", len_err, 1);
    pulse_clear();
    check("len_err_cleared", len_err, 0);

    // Back-to-back single-beat frames, handshake coincident with load
    beat(24'd77, 10'd5, 1'b1);
    show("single_a");
    check("single_a_value", m_peak_value, 77);
    check("single_a_index", m_peak_index, 5);
    beat(24'd33, 10'd1, 1'b1);
    show("single_b");
    check("single_b_tvalid", m_axis_tvalid, 1);
    check("single_b_found", m_peak_found, 0);
    check("single_b_value", m_peak_value, 0);
    check("single_b_overrun", overrun, 0);
    pulse_clear();

    // Pending result plus a partial frame, then reset mid-frame
    m_axis_tready = 1'b0;
    beat(24'd60, 10'd3, 1'b1);
    beat(24'd500, 10'd2, 1'b0);
    beat(24'd500, 10'd3, 1'b0);
    beat(24'd500, 10'd4, 1'b0);
    check("pre_rst_len_err", len_err, 1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    show("mid_reset");
    check("mid_rst_tvalid", m_axis_tvalid, 0);
    check("mid_rst_len_err", len_err, 0);
    check("mid_rst_value", m_peak_value, 0);
    @(negedge clk);
    rstn = 1'b1;
    m_axis_tready = 1'b1;
    send_frame(8, 24'd10, 0);
    show("frame_post_reset");
    check("post_rst_value", m_peak_value, 90);
    check("post_rst_index", m_peak_index, 4);
    check("post_rst_len_err", len_err, 0);
    @(posedge clk); #1;

    // Gapped tvalid: 1 on, 2 off
    send_frame(8, 24'd10, 2);
    show("frame_gapped");
    check("gap_tvalid", m_axis_tvalid, 1);
    check("gap_value", m_peak_value, 90);
    check("gap_index", m_peak_index, 4);
    check("gap_found", m_peak_found, 1);
    check("gap_len_err", len_err, 0);
`ifdef PEAK_ABOVE_COUNT_EN
    check("gap_count", m_peak_count, 4);
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
